// File: rtl/snn_frame_rx.sv
// SNN input-stream receiver. It captures one Opt/Img/Kernel/Weight burst into register buffers. Optional frm_cnt output: SNN_FRAME_RX_FRMCNT_EN.
// Latency: frm_valid rises one cycle after the last Weight beat. Read ports are combinational. Error pulses are registered and appear one cycle after the cause.
// Backpressure: none. Beats that arrive while a frame is held are dropped and flagged. Holding frm_release lets a new frame start.
module snn_frame_rx #(
    parameter int DW        = 32,
    parameter int IMG_BEATS = 96,
    parameter int KER_BEATS = 27,
    parameter int W_BEATS   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] Img,
    input  logic [DW-1:0] Kernel,
    input  logic [DW-1:0] Weight,
    input  logic [1:0]    Opt,
    output logic          frm_valid,
    output logic [1:0]    frm_opt,
    input  logic          frm_release,
    input  logic [6:0]    rd_img_addr,
    output logic [DW-1:0] rd_img_data,
    input  logic [4:0]    rd_ker_addr,
    output logic [DW-1:0] rd_ker_data,
    input  logic [1:0]    rd_w_addr,
    output logic [DW-1:0] rd_w_data,
`ifdef SNN_FRAME_RX_FRMCNT_EN
    output logic [15:0]   frm_cnt,
`endif
    output logic          err_short,
    output logic          err_overrun
);

    typedef enum logic [2:0] {IDLE, RX_IMG, RX_KER, RX_W, HOLD} state_t;

    localparam logic [6:0] IMG_LAST = 7'(IMG_BEATS - 1);
    localparam logic [6:0] KER_LAST = 7'(KER_BEATS - 1);
    localparam logic [6:0] W_LAST   = 7'(W_BEATS - 1);

    state_t        state, state_nxt;
    logic [6:0]    bc, bc_nxt;
    logic          img_we, ker_we, w_we, opt_we, done;
    logic [6:0]    img_wa;
    logic          short_nxt, overrun_nxt;

    logic [DW-1:0] img_buf [IMG_BEATS];
    logic [DW-1:0] ker_buf [KER_BEATS];
    logic [DW-1:0] w_buf   [W_BEATS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bc          <= '0;
            frm_opt     <= '0;
            err_short   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            bc          <= bc_nxt;
            err_short   <= short_nxt;
            err_overrun <= overrun_nxt;
            if (opt_we) frm_opt <= Opt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bc_nxt      = bc;
        img_we      = 1'b0;
        img_wa      = bc;
        ker_we      = 1'b0;
        w_we        = 1'b0;
        opt_we      = 1'b0;
        done        = 1'b0;
        short_nxt   = 1'b0;
        overrun_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    img_we    = 1'b1;
                    img_wa    = '0;
                    opt_we    = 1'b1;
                    bc_nxt    = 7'd1;
                    state_nxt = RX_IMG;
                end
            end
            RX_IMG: begin
                if (!in_valid) begin
                    short_nxt = 1'b1;
                    bc_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    img_we = 1'b1;
                    if (bc == IMG_LAST) begin
                        bc_nxt    = '0;
                        state_nxt = RX_KER;
                    end else begin
                        bc_nxt = bc + 7'd1;
                    end
                end
            end
            RX_KER: begin
                if (!in_valid) begin
                    short_nxt = 1'b1;
                    bc_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    ker_we = 1'b1;
                    if (bc == KER_LAST) begin
                        bc_nxt    = '0;
                        state_nxt = RX_W;
                    end else begin
                        bc_nxt = bc + 7'd1;
                    end
                end
            end
            RX_W: begin
                if (!in_valid) begin
                    short_nxt = 1'b1;
                    bc_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    w_we = 1'b1;
                    if (bc == W_LAST) begin
                        bc_nxt    = '0;
                        done      = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        bc_nxt = bc + 7'd1;
                    end
                end
            end
            HOLD: begin
                // Release takes priority, so a coincident beat becomes beat 0 of the next frame.
                if (frm_release) begin
                    bc_nxt    = '0;
                    state_nxt = IDLE;
                    if (in_valid) begin
                        img_we    = 1'b1;
                        img_wa    = '0;
                        opt_we    = 1'b1;
                        bc_nxt    = 7'd1;
                        state_nxt = RX_IMG;
                    end
                end else if (in_valid) begin
                    overrun_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                bc_nxt    = '0;
            end
        endcase
    end

    // Each buffer samples only its own lane, so X values on idle lanes never reach the stored data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMG_BEATS; i++) img_buf[i] <= '0;
            for (int i = 0; i < KER_BEATS; i++) ker_buf[i] <= '0;
            for (int i = 0; i < W_BEATS; i++)   w_buf[i]   <= '0;
        end else begin
            if (img_we) img_buf[img_wa] <= Img;
            if (ker_we) ker_buf[bc[$clog2(KER_BEATS)-1:0]] <= Kernel;
            if (w_we)   w_buf[bc[$clog2(W_BEATS)-1:0]]     <= Weight;
        end
    end

`ifdef SNN_FRAME_RX_FRMCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    frm_cnt <= '0;
        else if (done) frm_cnt <= frm_cnt + 16'd1;
    end
`endif

    assign frm_valid   = (state == HOLD);
    assign rd_img_data = ({1'b0, rd_img_addr} < 8'(IMG_BEATS)) ? img_buf[rd_img_addr] : '0;
    assign rd_ker_data = ({1'b0, rd_ker_addr} < 6'(KER_BEATS)) ? ker_buf[rd_ker_addr] : '0;
    assign rd_w_data   = ({1'b0, rd_w_addr}   < 3'(W_BEATS))   ? w_buf[rd_w_addr]     : '0;

endmodule

// File: tb/tb_snn_frame_rx.sv
// Bench for snn_frame_rx: it drives directed frames, reads the buffers back through a vector table, and checks the error and reset corner cases.
module tb_snn_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] Img, Kernel, Weight;
    logic [1:0]  Opt;
    logic        frm_valid;
    logic [1:0]  frm_opt;
    logic        frm_release;
    logic [6:0]  rd_img_addr;
    logic [31:0] rd_img_data;
    logic [4:0]  rd_ker_addr;
    logic [31:0] rd_ker_data;
    logic [1:0]  rd_w_addr;
    logic [31:0] rd_w_data;
    logic        err_short, err_overrun;
`ifdef SNN_FRAME_RX_FRMCNT_EN
    logic [15:0] frm_cnt;
`endif

    int tests = 0;
    int fails = 0;

    snn_frame_rx dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Img(Img), .Kernel(Kernel), .Weight(Weight), .Opt(Opt),
        .frm_valid(frm_valid), .frm_opt(frm_opt), .frm_release(frm_release),
        .rd_img_addr(rd_img_addr), .rd_img_data(rd_img_data),
        .rd_ker_addr(rd_ker_addr), .rd_ker_data(rd_ker_data),
        .rd_w_addr(rd_w_addr), .rd_w_data(rd_w_data),
`ifdef SNN_FRAME_RX_FRMCNT_EN
        .frm_cnt(frm_cnt),
`endif
        .err_short(err_short), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ia;
        logic [4:0]  ka;
        logic [1:0]  wa;
        logic [31:0] ie;
        logic [31:0] ke;
        logic [31:0] we;
    } rdvec_t;

    rdvec_t vec [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd(input logic [6:0] ia, input logic [4:0] ka, input logic [1:0] wa);
        rd_img_addr = ia;
        rd_ker_addr = ka;
        rd_w_addr   = wa;
        #1;
    endtask

    // Drives beats 0..nbeats-1 of a frame. Lanes that do not belong to the current section are driven to X.
    task automatic send_frame(input logic [1:0] opt, input logic [31:0] ib, input logic [31:0] kb,
                              input logic [31:0] wb, input logic rel, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            if (rel && i == 1) begin
                check("sim_rel_no_overrun", {31'd0, err_overrun}, 32'd0);
                check("sim_rel_valid_low", {31'd0, frm_valid}, 32'd0);
                check("sim_rel_opt", {30'd0, frm_opt}, {30'd0, opt});
            end
            if (i == 126) check("valid_before_last", {31'd0, frm_valid}, 32'd0);
            in_valid    = 1'b1;
            frm_release = rel && (i == 0);
            Opt         = (i == 0) ? opt : 2'bx;
            Img         = (i < 96) ? ib + 32'(i) : 32'hx;
            Kernel      = (i >= 96 && i < 123) ? kb + 32'(i - 96) : 32'hx;
            Weight      = (i >= 123) ? wb + 32'(i - 123) : 32'hx;
        end
        if (nbeats == 127) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("valid_after_last", {31'd0, frm_valid}, 32'd1);
        end
    endtask

    task automatic release_pulse();
        @(negedge clk);
        frm_release = 1'b1;
        @(negedge clk);
        frm_release = 1'b0;
    endtask

    initial begin
        int ov_cnt;
        vec[0] = '{7'd0,   5'd0,  2'd0, 32'h100, 32'h2000, 32'h3000};
        vec[1] = '{7'd95,  5'd26, 2'd3, 32'h15F, 32'h201A, 32'h3003};
        vec[2] = '{7'd100, 5'd27, 2'd1, 32'h0,   32'h0,    32'h3001};
        vec[3] = '{7'd127, 5'd31, 2'd2, 32'h0,   32'h0,    32'h3002};
        vec[4] = '{7'd50,  5'd13, 2'd0, 32'h132, 32'h200D, 32'h3000};

        rst_n = 1'b0; in_valid = 1'b0; frm_release = 1'b0;
        Img = '0; Kernel = '0; Weight = '0; Opt = '0;
        rd_img_addr = '0; rd_ker_addr = '0; rd_w_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_frm_valid", {31'd0, frm_valid}, 32'd0);
        check("rst_frm_opt", {30'd0, frm_opt}, 32'd0);
        check("rst_err_short", {31'd0, err_short}, 32'd0);
        check("rst_err_overrun", {31'd0, err_overrun}, 32'd0);
`ifdef SNN_FRAME_RX_FRMCNT_EN
        check("rst_frm_cnt", {16'd0, frm_cnt}, 32'd0);
`endif
        rst_n = 1'b1;

        // Short frame: 50 Img beats, then in_valid drops.
        send_frame(2'd1, 32'h500, 32'h0, 32'h0, 1'b0, 50);
        @(negedge clk);
        in_valid = 1'b0;
        check("short_pre", {31'd0, err_short}, 32'd0);
        @(negedge clk);
        check("short_pulse", {31'd0, err_short}, 32'd1);
        check("short_no_valid", {31'd0, frm_valid}, 32'd0);
        @(negedge clk);
        check("short_pulse_end", {31'd0, err_short}, 32'd0);
        check("short_still_invalid", {31'd0, frm_valid}, 32'd0);

        // Nominal frame, with readback driven from the vector table.
        send_frame(2'd2, 32'h100, 32'h2000, 32'h3000, 1'b0, 127);
        check("nom_opt", {30'd0, frm_opt}, 32'd2);
        for (int v = 0; v < 5; v++) begin
            rd(vec[v].ia, vec[v].ka, vec[v].wa);
            check($sformatf("img_rd[%0d]", vec[v].ia), rd_img_data, vec[v].ie);
            check($sformatf("ker_rd[%0d]", vec[v].ka), rd_ker_data, vec[v].ke);
            check($sformatf("w_rd[%0d]", vec[v].wa), rd_w_data, vec[v].we);
        end

        // Overrun: three beats while the frame is held, with no release.
        ov_cnt = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("overrun_%0d", j), {31'd0, err_overrun}, {31'd0, (j >= 1 && j <= 3)});
            if (err_overrun) ov_cnt++;
            in_valid = (j < 3);
            Img = 32'hBAD0BAD0; Kernel = 32'hBAD1BAD1; Weight = 32'hBAD2BAD2; Opt = 2'd0;
        end
        check("overrun_count", 32'(ov_cnt), 32'd3);
        check("overrun_held", {31'd0, frm_valid}, 32'd1);
        check("overrun_opt", {30'd0, frm_opt}, 32'd2);
        rd(7'd0, 5'd0, 2'd0);
        check("overrun_w0", rd_w_data, 32'h3000);
        check("overrun_img0", rd_img_data, 32'h100);

        // Release with in_valid low.
        release_pulse();
        check("release_valid", {31'd0, frm_valid}, 32'd0);
        check("release_no_overrun", {31'd0, err_overrun}, 32'd0);

        send_frame(2'd1, 32'hA0000000, 32'h2000, 32'h3000, 1'b0, 127);
        check("f2_opt", {30'd0, frm_opt}, 32'd1);
        rd(7'd0, 5'd0, 2'd0);
        check("f2_img0", rd_img_data, 32'hA0000000);
        rd(7'd95, 5'd0, 2'd0);
        check("f2_img95", rd_img_data, 32'hA000005F);

        // Release and beat 0 arrive in the same cycle.
        send_frame(2'd3, 32'hDEAD0000, 32'h2000, 32'h3000, 1'b1, 127);
        check("sim_opt", {30'd0, frm_opt}, 32'd3);
        rd(7'd0, 5'd4, 2'd3);
        check("sim_img0", rd_img_data, 32'hDEAD0000);
        check("sim_ker4", rd_ker_data, 32'h2004);
        check("sim_w3", rd_w_data, 32'h3003);
        release_pulse();

        // Reset asserted asynchronously in the middle of Kernel beat 10.
        send_frame(2'd2, 32'h100, 32'h2000, 32'h3000, 1'b0, 106);
        @(negedge clk);
        in_valid = 1'b1; Kernel = 32'h200A; Img = 32'hx; Weight = 32'hx;
        #2 rst_n = 1'b0;
        #1;
        check("arst_frm_opt", {30'd0, frm_opt}, 32'd0);
        check("arst_frm_valid", {31'd0, frm_valid}, 32'd0);
        check("arst_err_short", {31'd0, err_short}, 32'd0);
        check("arst_err_overrun", {31'd0, err_overrun}, 32'd0);
        rd(7'd5, 5'd3, 2'd0);
        check("arst_img5", rd_img_data, 32'h0);
        check("arst_ker3", rd_ker_data, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(2'd2, 32'h700, 32'h2100, 32'h3100, 1'b0, 127);
        check("fresh_opt", {30'd0, frm_opt}, 32'd2);
        rd(7'd95, 5'd26, 2'd3);
        check("fresh_img95", rd_img_data, 32'h75F);
        check("fresh_ker26", rd_ker_data, 32'h211A);
        check("fresh_w3", rd_w_data, 32'h3103);
`ifdef SNN_FRAME_RX_FRMCNT_EN
        check("fresh_frm_cnt", {16'd0, frm_cnt}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
